seven_disp_axi_slave: RTL and testbench

SEVEN_DISP_AXI_SLAVE -- requirements
Module: seven_disp_axi_slave

---
 rtl/seven_disp_axi_slave.sv | 139 +++++++++++++
 tb/tb_seven_disp_axi_slave.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_disp_axi_slave.sv
// AXI4-Lite controlled 8-digit multiplexed seven-segment driver (DIGITS/MASK/PRESCALE/CTRL).
// Define SEVEN_DISP_WSTRB_EN to honour wstrb byte lanes on register writes.
module seven_disp_axi_slave #(
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
   input  logic                                s00_axi_aclk,
   input  logic                                s00_axi_reset,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                          s00_axi_awprot,
   input  logic                                s00_axi_awvalid,
   output logic                                s00_axi_awready,
   input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                                s00_axi_wvalid,
   output logic                                s00_axi_wready,
   output logic [1:0]                          s00_axi_bresp,
   output logic                                s00_axi_bvalid,
   input  logic                                s00_axi_bready,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                          s00_axi_arprot,
   input  logic                                s00_axi_arvalid,
   output logic                                s00_axi_arready,
   output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                          s00_axi_rresp,
   output logic                                s00_axi_rvalid,
   input  logic                                s00_axi_rready,
   output logic [7:0]                          an,
   output logic [6:0]                          seg,
   output logic                                dp
);

   logic [31:0] regs_q [4];
   logic        awready_q, bvalid_q, arready_q, rvalid_q;
   logic [31:0] rdata_q;
   logic [15:0] cnt_q;
   logic [2:0]  idx_q;
   logic [7:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic        wr_hs, rd_hs;
   logic [3:0]  wr_be;
   logic [1:0]  wr_sel, rd_sel;

   logic unused_ok;
   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0], s00_axi_wstrb};

   assign wr_hs  = awready_q & s00_axi_awvalid & s00_axi_wvalid;
   assign rd_hs  = arready_q & s00_axi_arvalid;
   assign wr_sel = s00_axi_awaddr[3:2];
   assign rd_sel = s00_axi_araddr[3:2];
`ifdef SEVEN_DISP_WSTRB_EN
   assign wr_be  = s00_axi_wstrb[3:0];
`else
   assign wr_be  = 4'hF;
`endif

   // Ready is registered: raised for one cycle once both channels are valid and no response is pending.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_reset) begin
         for (int r = 0; r < 4; r++) regs_q[r] <= '0;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         awready_q <= s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q;
         arready_q <= s00_axi_arvalid & ~rvalid_q & ~arready_q;
         if (wr_hs) begin
            for (int b = 0; b < 4; b++)
               if (wr_be[b]) regs_q[wr_sel][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
            bvalid_q <= 1'b1;
         end else if (bvalid_q && s00_axi_bready) begin
            bvalid_q <= 1'b0;
         end
         if (rd_hs) begin
            rdata_q  <= regs_q[rd_sel];
            rvalid_q <= 1'b1;
         end else if (rvalid_q && s00_axi_rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   function automatic logic [6:0] glyph(input logic [3:0] h);
      case (h)
         4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      an_d  = 8'hFF;
      an_d[idx_q] = ~(regs_q[1][8 + idx_q] & ~regs_q[3][0]);
      seg_d = glyph(regs_q[0][{idx_q, 2'b00} +: 4]);
      dp_d  = an_d[idx_q] | ~regs_q[1][idx_q];
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_reset) begin
         cnt_q <= '0;
         idx_q <= '0;
         an_q  <= 8'hFF;
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
      end else begin
         if (cnt_q >= regs_q[2][15:0]) begin
            cnt_q <= '0;
            idx_q <= idx_q + 3'd1;
         end else begin
            cnt_q <= cnt_q + 16'd1;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign s00_axi_awready = awready_q;
   assign s00_axi_wready  = awready_q;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_bresp   = 2'b00;
   assign s00_axi_arready = arready_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = 2'b00;
   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seven_disp_axi_slave.sv
// Directed bench for seven_disp_axi_slave: register access, handshakes, display scan, blanking, reset.
module tb_seven_disp_axi_slave;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata, rd;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   int          n_tests = 0, n_fail = 0;
   bit          ok;

   always #5 clk = ~clk;

   seven_disp_axi_slave dut (
      .s00_axi_aclk(clk), .s00_axi_reset(rst),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
      .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
      .an(an), .seg(seg), .dp(dp));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      bit hs = 0, bv = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      for (int i = 0; i < 20 && !hs; i++) begin
         @(negedge clk);
         if (awready && wready) hs = 1;
      end
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      if (!hs) chk("awready_timeout", 0, 1);
      for (int i = 0; i < 20 && hs && !bv; i++) begin
         if (bvalid) bv = 1; else @(negedge clk);
      end
      if (hs) begin
         chk("bvalid_seen", 32'(bv), 1);
         chk("bresp", 32'(bresp), 0);
         bready = 1;
         @(negedge clk);
         bready = 0;
      end
   endtask

   task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
      bit hs = 0, rv = 0;
      d = 32'hxxxxxxxx;
      araddr = a; arvalid = 1;
      for (int i = 0; i < 20 && !hs; i++) begin
         @(negedge clk);
         if (arready) hs = 1;
      end
      @(negedge clk);
      arvalid = 0;
      if (!hs) chk("arready_timeout", 0, 1);
      for (int i = 0; i < 20 && hs && !rv; i++) begin
         if (rvalid) rv = 1; else @(negedge clk);
      end
      if (hs) begin
         chk("rvalid_seen", 32'(rv), 1);
         chk("rresp", 32'(rresp), 0);
         d = rdata;
         rready = 1;
         @(negedge clk);
         rready = 0;
      end
   endtask

   // Bounded wait for an to become equal (eq=1) or unequal (eq=0) to v.
   task automatic wait_an(input logic [7:0] v, input bit eq);
      bit hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if ((an == v) == eq) hit = 1; else @(negedge clk);
      end
      if (!hit) chk("an_sync_timeout", 0, 1);
   endtask

   initial begin
      rst = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0; awvalid = 0; wvalid = 0;
      wdata = 0; wstrb = 0; bready = 0; arvalid = 0; rready = 0;
      repeat (3) @(negedge clk);
      chk("rst_an", 32'(an), 32'hFF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 1);
      chk("rst_handshake", 32'({awready, wready, bvalid, arready, rvalid}), 0);
      rst = 0;
      @(negedge clk);

      // Basic write then readback of all four registers
      for (int i = 0; i < 4; i++) axi_wr(4'(4*i), 32'(i + 1), 4'hF);
      for (int i = 0; i < 4; i++) begin
         axi_rd(4'(4*i), rd);
         chk($sformatf("readback_r%0d", i), rd, 32'(i + 1));
      end
      axi_rd(4'h5, rd);
      chk("addr_low_bits_ignored", rd, 32'h2);

      // Byte strobes
      axi_wr(4'h0, 32'h00000001, 4'hF);
      axi_wr(4'h0, 32'hAABBCCDD, 4'b0001);
      axi_rd(4'h0, rd);
`ifdef SEVEN_DISP_WSTRB_EN
      chk("wstrb_partial", rd, 32'h000000DD);
`else
      chk("wstrb_ignored", rd, 32'hAABBCCDD);
`endif

      // All 32 bits stored, including unused ones
      axi_wr(4'hC, 32'hDEADBEEF, 4'hF);
      axi_rd(4'hC, rd);
      chk("ctrl_all_bits", rd, 32'hDEADBEEF);
      axi_wr(4'hC, 32'h0, 4'hF);

      // Display scan
      axi_wr(4'h0, 32'h76543210, 4'hF);
      axi_wr(4'h4, 32'h0000FF01, 4'hF);
      axi_wr(4'h8, 32'h3, 4'hF);
      wait_an(8'hFE, 0);
      wait_an(8'hFE, 1);
      for (int k = 0; k < 9; k++) begin
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("scan_an_k%0d_c%0d", k, c), 32'(an), 32'(~(8'h01 << (k % 8)) & 8'hFF));
            if (c == 0 && k == 0) begin
               chk("scan_seg_d0", 32'(seg), 32'b1000000);
               chk("scan_dp_d0", 32'(dp), 0);
            end
            if (c == 0 && k == 1) begin
               chk("scan_seg_d1", 32'(seg), 32'b1111001);
               chk("scan_dp_d1", 32'(dp), 1);
            end
            if (c == 0 && k == 7) begin
               chk("scan_seg_d7", 32'(seg), 32'b1111000);
               chk("scan_dp_d7", 32'(dp), 1);
            end
            @(negedge clk);
         end
      end

      // Global blank
      axi_wr(4'h4, 32'h0000FF00, 4'hF);
      axi_wr(4'hC, 32'h1, 4'hF);
      repeat (6) @(negedge clk);
      for (int c = 0; c < 8; c++) begin
         chk("blank_an", 32'(an), 32'hFF);
         chk("blank_dp", 32'(dp), 1);
         @(negedge clk);
      end
      axi_wr(4'hC, 32'h0, 4'hF);

      // Write response backpressure
      awaddr = 4'h0; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (awready) ok = 1;
      end
      @(negedge clk);
      chk("bp_first_accept", 32'(ok), 1);
      awaddr = 4'h8; wdata = 32'h00000005;
      for (int i = 0; i < 5; i++) begin
         chk("bp_bvalid_held", 32'(bvalid), 1);
         chk("bp_bresp", 32'(bresp), 0);
         chk("bp_no_awready", 32'(awready), 0);
         @(negedge clk);
      end
      bready = 1;
      @(negedge clk);
      bready = 0;
      chk("bp_bvalid_cleared", 32'(bvalid), 0);
      chk("bp_awready_still_low", 32'(awready), 0);
      @(negedge clk);
      chk("bp_awready_after", 32'(awready), 1);
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      chk("bp_second_bvalid", 32'(bvalid), 1);
      bready = 1;
      @(negedge clk);
      bready = 0;
      axi_rd(4'h0, rd);
      chk("bp_first_data", rd, 32'h11111111);
      axi_rd(4'h8, rd);
      chk("bp_second_data", rd, 32'h5);

      // Reset during an in-flight read
      araddr = 4'h0; arvalid = 1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (arready) ok = 1;
      end
      chk("rst_rd_arready", 32'(ok), 1);
      rst = 1;
      @(negedge clk);
      arvalid = 0;
      chk("rstrd_rvalid", 32'(rvalid), 0);
      chk("rstrd_an", 32'(an), 32'hFF);
      chk("rstrd_seg", 32'(seg), 32'h7F);
      chk("rstrd_dp", 32'(dp), 1);
      chk("rstrd_ready", 32'({awready, bvalid, arready}), 0);
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         chk("rstrd_no_late_rvalid", 32'(rvalid), 0);
         @(negedge clk);
      end
      axi_rd(4'h0, rd);
      chk("rstrd_digits_cleared", rd, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
